hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 16-bit five-stage pipeline.
- Drives write-enables and NOP-injection controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Arbitrates the single shared RAM port between instruction fetch and MEM-stage load/store, using a multi-cycle wait FSM.
- Also handles load-use stalls and taken-branch flushes.

---
 rtl/hazard_ctrl_pkg.sv | 17 +
 rtl/hazard_detect.sv | 19 +
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared configuration for the pipeline hazard sequencer: FSM encodings,
// RAM-owner codes and the pipeline NOP word.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic RAM_IF  = 1'b0;
    localparam logic RAM_MEM = 1'b1;

    // Instruction word loaded into IF/ID on flush.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the ID instruction reads a register that the
// load currently in EX will write.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [2:0] id_rx,
    input  logic [2:0] id_ry,
    input  logic       id_use_rx,
    input  logic       id_use_ry,
    input  logic       ex_mem_read,
    input  logic [2:0] ex_rd,
    output logic       load_use
);

    assign load_use = ex_mem_read &
                      ((id_use_rx & (id_rx == ex_rd)) |
                       (id_use_ry & (id_ry == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; also arbitrates the
// shared RAM port between instruction fetch and the MEM stage.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] IdRx,
    input  logic [2:0] IdRy,
    input  logic       IdUseRx,
    input  logic       IdUseRy,
    input  logic       ExMemRead,
    input  logic [2:0] ExRd,
    input  logic       MemReq,
    input  logic       BranchTaken,
    output logic       PcWrite,
    output logic       PcSel,
    output logic       IfIdWrite,
    output logic       IfIdRst,
    output logic       IdExWrite,
    output logic       IdExRst,
    output logic       ExMemWrite,
    output logic       MemWbRst,
    output logic       RamSel,
    output logic       MemAck,
    output logic       Stalling
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    hazard_detect u_detect (
        .id_rx       (IdRx),
        .id_ry       (IdRy),
        .id_use_rx   (IdUseRx),
        .id_use_ry   (IdUseRy),
        .ex_mem_read (ExMemRead),
        .ex_rd       (ExRd),
        .load_use    (load_use)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        PcWrite    = 1'b1;
        PcSel      = 1'b0;
        IfIdWrite  = 1'b1;
        IfIdRst    = 1'b0;
        IdExWrite  = 1'b1;
        IdExRst    = 1'b0;
        ExMemWrite = 1'b1;
        MemWbRst   = 1'b0;
        RamSel     = RAM_IF;
        MemAck     = 1'b0;
        Stalling   = 1'b0;

        case (state_q)
            ST_RUN: begin
                // The fetch in this cycle still completes; MEM takes the port next cycle.
                if (MemReq) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                end
                if (BranchTaken) begin
                    PcSel   = 1'b1;
                    IfIdRst = 1'b1;
                    IdExRst = 1'b1;
                end else if (load_use) begin
                    PcWrite   = 1'b0;
                    IfIdWrite = 1'b0;
                    IdExRst   = 1'b1;
                end
            end
            ST_WAIT: begin
                RamSel     = RAM_MEM;
                Stalling   = 1'b1;
                PcWrite    = 1'b0;
                IfIdWrite  = 1'b0;
                IdExWrite  = 1'b0;
                ExMemWrite = 1'b0;
                if (cnt_q != '0) begin
                    MemWbRst = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    MemAck  = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                Stalling = 1'b1;
                state_d  = ST_RUN;
                if (BranchTaken) begin
                    PcSel   = 1'b1;
                    IfIdRst = 1'b1;
                    IdExRst = 1'b1;
                end else if (load_use) begin
                    PcWrite   = 1'b0;
                    IfIdWrite = 1'b0;
                    IdExRst   = 1'b1;
                end else begin
                    // Fetch slot was lost to MEM: squash it and refetch the same PC.
                    PcWrite = 1'b0;
                    IfIdRst = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (!Rst) begin
            PcWrite    = 1'b0;
            PcSel      = 1'b0;
            IfIdWrite  = 1'b0;
            IfIdRst    = 1'b1;
            IdExWrite  = 1'b0;
            IdExRst    = 1'b1;
            ExMemWrite = 1'b0;
            MemWbRst   = 1'b1;
            RamSel     = RAM_IF;
            MemAck     = 1'b0;
            Stalling   = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Checks two hazard_ctrl instances (WAIT_CYCLES=2 and 1) against a
// phase-index reference model under directed and random stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] id_rx, id_ry, ex_rd;
    logic       id_use_rx, id_use_ry, ex_mem_read, mem_req, branch;

    // {PcWrite,PcSel,IfIdWrite,IfIdRst,IdExWrite,IdExRst,ExMemWrite,MemWbRst,RamSel,MemAck,Stalling}
    logic [10:0] out2, out1;

    int total = 0;
    int bad   = 0;
    int k2 = -1, k1 = -1;           // -1 = running, 0..W-1 = wait cycle index, W = release
    int acks_dut2 = 0, acks_dut1 = 0;
    int acks_exp2 = 0, acks_exp1 = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_CYCLES(2), .CNT_W(4)) dut_w2 (
        .Clk(clk), .Rst(rst_n), .IdRx(id_rx), .IdRy(id_ry),
        .IdUseRx(id_use_rx), .IdUseRy(id_use_ry), .ExMemRead(ex_mem_read),
        .ExRd(ex_rd), .MemReq(mem_req), .BranchTaken(branch),
        .PcWrite(out2[10]), .PcSel(out2[9]), .IfIdWrite(out2[8]), .IfIdRst(out2[7]),
        .IdExWrite(out2[6]), .IdExRst(out2[5]), .ExMemWrite(out2[4]), .MemWbRst(out2[3]),
        .RamSel(out2[2]), .MemAck(out2[1]), .Stalling(out2[0])
    );

    hazard_ctrl #(.WAIT_CYCLES(1), .CNT_W(4)) dut_w1 (
        .Clk(clk), .Rst(rst_n), .IdRx(id_rx), .IdRy(id_ry),
        .IdUseRx(id_use_rx), .IdUseRy(id_use_ry), .ExMemRead(ex_mem_read),
        .ExRd(ex_rd), .MemReq(mem_req), .BranchTaken(branch),
        .PcWrite(out1[10]), .PcSel(out1[9]), .IfIdWrite(out1[8]), .IfIdRst(out1[7]),
        .IdExWrite(out1[6]), .IdExRst(out1[5]), .ExMemWrite(out1[4]), .MemWbRst(out1[3]),
        .RamSel(out1[2]), .MemAck(out1[1]), .Stalling(out1[0])
    );

    function automatic bit model_lu();
        return ex_mem_read && ((id_use_rx && id_rx == ex_rd) || (id_use_ry && id_ry == ex_rd));
    endfunction

    // Expected outputs for an access phase k of a controller with W wait cycles.
    function automatic logic [10:0] model_out(int k, int w, bit rst_ok, bit br, bit lu);
        bit pw = 1, ps = 0, ifw = 1, ifr = 0, idw = 1, idr = 0, exw = 1, mwr = 0, ram = 0, ack = 0, st = 0;
        if (!rst_ok) return 11'b000_1_0_1_0_1_000;
        if (k < 0) begin
            if (br) begin ps = 1; ifr = 1; idr = 1; end
            else if (lu) begin pw = 0; ifw = 0; idr = 1; end
        end else if (k < w) begin
            ram = 1; st = 1; pw = 0; ifw = 0; idw = 0; exw = 0;
            if (k == w - 1) ack = 1; else mwr = 1;
        end else begin
            st = 1;
            if (br) begin ps = 1; ifr = 1; idr = 1; end
            else if (lu) begin pw = 0; ifw = 0; idr = 1; end
            else begin pw = 0; ifr = 1; end
        end
        return {pw, ps, ifw, ifr, idw, idr, exw, mwr, ram, ack, st};
    endfunction

    function automatic int model_next(int k, int w, bit req);
        if (k < 0) return req ? 0 : -1;
        if (k < w) return k + 1;
        return -1;
    endfunction

    task automatic check(string tag, logic [10:0] got, logic [10:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    // Inputs are already driven (at negedge); check outputs, then advance one clock.
    task automatic step(string tag);
        logic [10:0] e2, e1;
        if (!rst_n) begin k2 = -1; k1 = -1; end
        #2;
        e2 = model_out(k2, 2, rst_n, branch, model_lu());
        e1 = model_out(k1, 1, rst_n, branch, model_lu());
        check({tag, "/w2"}, out2, e2);
        check({tag, "/w1"}, out1, e1);
        $display("step %-10s rst=%0b req=%0b br=%0b lu=%0b w2=%b w1=%b",
                 tag, rst_n, mem_req, branch, model_lu(), out2, out1);
        acks_dut2 += int'(out2[1]);
        acks_dut1 += int'(out1[1]);
        @(posedge clk);
        if (rst_n) begin
            k2 = model_next(k2, 2, mem_req);
            k1 = model_next(k1, 1, mem_req);
            if (k2 == 2) acks_exp2++;
            if (k1 == 1) acks_exp1++;
        end
        @(negedge clk);
    endtask

    task automatic set_in(bit req, bit br, bit rd_ld, logic [2:0] rd, logic [2:0] rx, bit urx,
                          logic [2:0] ry, bit ury);
        mem_req = req; branch = br; ex_mem_read = rd_ld; ex_rd = rd;
        id_rx = rx; id_use_rx = urx; id_ry = ry; id_use_ry = ury;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        @(negedge clk);
        step("reset");
        step("reset");
        rst_n = 1'b1;
        step("run_idle");

        // Load-use stall, then same regs without the read-enable.
        set_in(0, 0, 1, 3'd3, 3'd3, 1, 3'd5, 0);
        step("load_use");
        set_in(0, 0, 1, 3'd3, 3'd3, 0, 3'd5, 0);
        step("no_use");
        set_in(0, 0, 1, 3'd6, 3'd1, 0, 3'd6, 1);
        step("lu_ry");

        // Single memory access, then idle through completion.
        set_in(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        step("mem_req");
        mem_req = 1'b0;
        for (int i = 0; i < 5; i++) step("mem_seq");

        // Branch wins over load-use in RUN.
        set_in(0, 1, 1, 3'd2, 3'd2, 1, 3'd2, 1);
        step("br_lu");

        // Branch held through an access.
        set_in(1, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        step("br_req");
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++) step("br_wait");
        branch = 1'b0;

        // Load-use pending across release.
        set_in(1, 0, 1, 3'd4, 3'd4, 1, 3'd0, 0);
        step("lu_req");
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++) step("lu_wait");

        // Back-to-back: MemReq held high.
        set_in(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        for (int i = 0; i < 10; i++) step("b2b");
        mem_req = 1'b0;
        for (int i = 0; i < 4; i++) step("b2b_end");

        // Asynchronous reset in the middle of an access (w2 has cnt=1).
        mem_req = 1'b1;
        step("pre_rst");
        mem_req = 1'b0;
        rst_n = 1'b0;
        step("rst_mid");
        rst_n = 1'b1;
        step("post_rst");
        step("post_rst");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                   3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), $urandom_range(0, 1),
                   3'($urandom_range(0, 3)), $urandom_range(0, 1));
            step("rand");
        end
        set_in(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0);
        for (int i = 0; i < 4; i++) step("drain");

        total++;
        assert (acks_dut2 == acks_exp2) else begin
            bad++;
            $error("FAIL ack_count_w2 got=%0d want=%0d", acks_dut2, acks_exp2);
        end
        total++;
        assert (acks_dut1 == acks_exp1) else begin
            bad++;
            $error("FAIL ack_count_w1 got=%0d want=%0d", acks_dut1, acks_exp1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
